// File: rtl/fetch_sequencer_pkg.sv
// Shared processor package for the fetch sequencer.
// Holds the FSM state encoding, the sequential PC increment, the legality
// check applied to every PC the sequencer is about to use, and the program
// image loaded into instruction memory on reset.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN = 32;

    // Sequential fetch advances by one 32-bit word.
    localparam logic [XLEN-1:0] PC_INCR = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ISSUE   = 3'd2,
        EXECUTE = 3'd3,
        FAULT   = 3'd4
    } state_t;

    // A PC is unusable when it is not word aligned or lies past the last word.
    function automatic logic pc_illegal(input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

    // Program image: word 0 is 32'h2008_0005, each later word bumps both halves by one.
    function automatic logic [XLEN-1:0] imem_init(input int unsigned idx);
        logic [15:0] step;
        step = 16'(idx);
        return {16'h2008 + step, 16'h0005 + step};
    endfunction

endpackage

// File: rtl/fetch_sequencer_imem.sv
// Instruction memory for the fetch sequencer.
// The program image is held in flops that load from the package image on
// reset; reads are combinational so the sequencer can capture the word at
// the edge that ends its FETCH cycle.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset (reloads the image)
//   addr   - word index (byte PC bits [AW+1:2])
//   rdata  - instruction word at addr, zero past the last word
module fetch_sequencer_imem
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned WORDS = 64,
    parameter int unsigned AW    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   addr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [WORDS];

    // Image load on reset; contents are otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i[AW-1:0]] <= imem_init(i);
            end
        end
    end

    // Combinational read; indices beyond the depth return zero.
    always_comb begin
        rdata = '0;
        if (32'(addr) < WORDS) begin
            rdata = mem[addr];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks IDLE -> FETCH -> ISSUE -> EXECUTE -> FETCH ...,
// presenting one registered instruction at a time to the core and choosing
// the next PC on retire (sequential or redirected). Any unusable next PC
// (misaligned or past the memory) parks the sequencer in FAULT until reset.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   instr_ready    - core accepts the presented instruction (ISSUE only)
//   retire         - core finished the accepted instruction (EXECUTE only)
//   redirect       - with retire: next PC is redirect_pc instead of pc+4
//   redirect_pc    - branch/jump target
//   pc             - address of the instruction being fetched/issued
//   instruction    - registered instruction word
//   instr_valid    - instruction presented and not yet accepted
//   fault          - sticky illegal-PC flag
//   retired_count  - wrapping count of retired instructions
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_ready,
    input  logic        retire,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] retired_count
);

    localparam int unsigned AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    state_t      state;
    logic [31:0] imem_rdata;
    logic [31:0] next_pc_c;
    logic        next_bad_c;

    fetch_sequencer_imem #(
        .WORDS (IMEM_WORDS),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .rst   (rst),
        .addr  (pc[AW+1:2]),
        .rdata (imem_rdata)
    );

    // Candidate next PC and its legality; pc+4 wraps naturally at 2^32.
    always_comb begin
        next_pc_c  = pc + PC_INCR;
        if (redirect) begin
            next_pc_c = redirect_pc;
        end
        next_bad_c = pc_illegal(next_pc_c, PC_LIMIT);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instruction   <= '0;
            instr_valid   <= 1'b0;
            fault         <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                // One settling cycle; an unusable reset PC never fetches.
                IDLE: begin
                    if (pc_illegal(pc, PC_LIMIT)) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    instruction <= imem_rdata;
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
                end
                // retire arriving with instr_ready is dropped here.
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= EXECUTE;
                    end
                end
                // The retire counts even when its next PC faults.
                EXECUTE: begin
                    if (retire) begin
                        retired_count <= retired_count + 32'd1;
                        if (next_bad_c) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc    <= next_pc_c;
                            state <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue of expected (pc, word)
// fetches is filled as retires are driven and drained as the DUT issues.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_ready;
    logic        retire;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc, instruction, retired_count;
    logic        instr_valid, fault;

    logic [31:0] b_pc, b_instruction, b_retired_count;
    logic        b_instr_valid, b_fault;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_ready   (instr_ready),
        .retire        (retire),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .fault         (fault),
        .retired_count (retired_count)
    );

    // Second instance with a misaligned reset PC.
    fetch_sequencer #(
        .RESET_PC   (32'h0000_0002),
        .IMEM_WORDS (4)
    ) dut_bad (
        .clk           (clk),
        .rst           (rst),
        .instr_ready   (instr_ready),
        .retire        (retire),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc            (b_pc),
        .instruction   (b_instruction),
        .instr_valid   (b_instr_valid),
        .fault         (b_fault),
        .retired_count (b_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_t;

    fetch_t      sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent model of the program image.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        return {16'h2008 + idx[15:0], 16'h0005 + idx[15:0]};
    endfunction

    function automatic logic legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < 32'd256);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_pc = a;
        sb.push_back({a, rom_word(a)});
    endtask

    // Wait (bounded) for an issued instruction and compare it with the queue head.
    task automatic wait_issue(input string tag);
        fetch_t e;
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            check32({tag, "_timeout"}, 32'(instr_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check32({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check32({tag, "_pc"}, pc, e.pc);
            check32({tag, "_instr"}, instruction, e.word);
        end
    endtask

    // Drive one retire from EXECUTE and update the model.
    task automatic retire_one(input logic redir, input logic [31:0] tgt, input string tag);
        logic [31:0] nxt;
        nxt         = redir ? tgt : exp_pc + 32'd4;
        retire      = 1'b1;
        redirect    = redir;
        redirect_pc = tgt;
        step();
        retire      = 1'b0;
        redirect    = 1'b0;
        exp_count   = exp_count + 32'd1;
        if (legal(nxt)) begin
            expect_fetch(nxt);
        end
        check32({tag, "_count"}, retired_count, exp_count);
    endtask

    task automatic restart();
        rst = 1'b0;
        step();
        rst       = 1'b1;
        exp_count = '0;
        expect_fetch(32'h0);
        wait_issue("restart");
        step();
    endtask

    initial begin
        rst         = 1'b0;
        instr_ready = 1'b0;
        retire      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        exp_count   = '0;
        exp_pc      = '0;
        repeat (3) step();

        check32("rst_pc", pc, 32'h0);
        check32("rst_instr", instruction, 32'h0);
        check32("rst_valid", 32'(instr_valid), 32'd0);
        check32("rst_fault", 32'(fault), 32'd0);
        check32("rst_count", retired_count, 32'h0);
        check32("bad_rst_fault", 32'(b_fault), 32'd0);

        // Release with instr_ready held high.
        instr_ready = 1'b1;
        rst         = 1'b1;
        step();
        check32("idle_valid", 32'(instr_valid), 32'd0);
        check32("bad_idle_fault", 32'(b_fault), 32'd1);
        check32("bad_idle_pc", b_pc, 32'h2);
        expect_fetch(32'h0);
        step();
        check32("first_valid", 32'(instr_valid), 32'd1);
        wait_issue("first");
        step();
        check32("exec_valid", 32'(instr_valid), 32'd0);
        check32("bad_no_fetch", 32'(b_instr_valid), 32'd0);

        // Three sequential retires.
        for (int i = 0; i < 3; i++) begin
            retire_one(1'b0, 32'h0, "seq");
            wait_issue("seq");
            step();
        end
        check32("seq_total", retired_count, 32'd3);

        // Redirected retire.
        retire_one(1'b1, 32'h10, "redir");
        wait_issue("redir");
        step();

        // Stall in ISSUE for five cycles.
        instr_ready = 1'b0;
        retire_one(1'b0, 32'h0, "stall");
        wait_issue("stall");
        for (int i = 0; i < 5; i++) begin
            step();
            check32("stall_valid", 32'(instr_valid), 32'd1);
            check32("stall_pc", pc, exp_pc);
            check32("stall_instr", instruction, rom_word(exp_pc));
        end

        // instr_ready with retire in ISSUE: retire dropped.
        instr_ready = 1'b1;
        retire      = 1'b1;
        step();
        retire = 1'b0;
        check32("dual_valid", 32'(instr_valid), 32'd0);
        check32("dual_count", retired_count, exp_count);

        // Asynchronous reset mid-EXECUTE while retire is asserted.
        retire = 1'b1;
        #1 rst = 1'b0;
        #1;
        check32("async_pc", pc, 32'h0);
        check32("async_instr", instruction, 32'h0);
        check32("async_valid", 32'(instr_valid), 32'd0);
        check32("async_count", retired_count, 32'h0);
        retire = 1'b0;
        step();
        rst       = 1'b1;
        exp_count = '0;
        expect_fetch(32'h0);
        wait_issue("resume");
        step();
        check32("resume_count", retired_count, 32'h0);

        // Misaligned redirect faults; later activity ignored.
        retire_one(1'b1, 32'h6, "misal");
        check32("misal_fault", 32'(fault), 32'd1);
        check32("misal_pc", pc, exp_pc);
        retire = 1'b1;
        repeat (4) step();
        retire = 1'b0;
        check32("fault_count", retired_count, exp_count);
        check32("fault_valid", 32'(instr_valid), 32'd0);
        check32("fault_pc", pc, exp_pc);
        check32("fault_sticky", 32'(fault), 32'd1);

        // Out-of-range redirect.
        restart();
        check32("restart_fault", 32'(fault), 32'd0);
        retire_one(1'b1, 32'h100, "range");
        check32("range_fault", 32'(fault), 32'd1);
        check32("range_pc", pc, exp_pc);

        // Last legal word, then pc+4 runs off the end.
        restart();
        retire_one(1'b1, 32'hFC, "last");
        wait_issue("last");
        step();
        retire_one(1'b0, 32'h0, "over");
        check32("over_fault", 32'(fault), 32'd1);
        check32("over_pc", pc, 32'hFC);

        check32("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
